// File: rtl/round_sequencer.sv
// Round sequencer for a two-player "ring the bell" card game: deals a card pair,
// opens a timed bell window, accepts the first armed bell press and counts rounds.
module round_sequencer #(
    parameter int ROUNDS   = 10,
    parameter int WINDOW   = 200,
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] keypad_in,
    output logic       card_req,
    input  logic       card_valid,
    input  logic [9:0] card_data,
    output logic [1:0] c1,
    output logic [2:0] n1,
    output logic [1:0] c2,
    output logic [2:0] n2,
    input  logic       right_in,
    output logic [1:0] who,
    output logic       right_q,
    output logic [7:0] count,
    output logic [3:0] round_cnt,
    output logic       game_over
);

    localparam logic [3:0] BELL_P1    = 4'b0111;
    localparam logic [3:0] BELL_P2    = 4'b1001;
    localparam int         DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV - 1);
    localparam logic [7:0] WIN_LOAD   = 8'(WINDOW);
    localparam logic [3:0] ROUND_LAST = 4'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAL  = 3'd1,
        SHOW  = 3'd2,
        JUDGE = 3'd3,
        HOLD  = 3'd4,
        NEXT  = 3'd5,
        OVER  = 3'd6
    } state_t;

    function automatic logic is_bell(input logic [3:0] code);
        return (code == BELL_P1) || (code == BELL_P2);
    endfunction

    function automatic logic [1:0] bell_player(input logic [3:0] code);
        logic [1:0] p;
        case (code)
            BELL_P1: p = 2'b01;
            BELL_P2: p = 2'b10;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    state_t           state_q, state_d;
    logic             card_req_q, card_req_d;
    logic [1:0]       c1_q, c1_d;
    logic [2:0]       n1_q, n1_d;
    logic [1:0]       c2_q, c2_d;
    logic [2:0]       n2_q, n2_d;
    logic [1:0]       who_q, who_d;
    logic             rq_q, rq_d;
    logic [7:0]       count_q, count_d;
    logic [3:0]       round_q, round_d;
    logic             game_over_q, game_over_d;
    logic [7:0]       win_q, win_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             armed_q, armed_d;

    logic             bell_s;
    logic             tick_s;
    logic [3:0]       round_inc_s;

    assign bell_s      = is_bell(keypad_in);
    assign tick_s      = (div_q == '0);
    assign round_inc_s = round_q + 4'd1;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        c1_d        = c1_q;
        n1_d        = n1_q;
        c2_d        = c2_q;
        n2_d        = n2_q;
        who_d       = 2'b00;
        rq_d        = rq_q;
        count_d     = count_q;
        round_d     = round_q;
        win_d       = win_q;
        div_d       = div_q;
        armed_d     = armed_q;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    round_d = 4'd0;
                    state_d = DEAL;
                end else begin
                    state_d = state_q;
                end
            end
            DEAL: begin
                if (card_valid) begin
                    c1_d    = card_data[9:8];
                    n1_d    = card_data[7:5];
                    c2_d    = card_data[4:3];
                    n2_d    = card_data[2:0];
                    win_d   = WIN_LOAD;
                    div_d   = DIV_LOAD;
                    // A bell already held when the cards appear must be released first.
                    armed_d = ~bell_s;
                    state_d = SHOW;
                end else begin
                    state_d = DEAL;
                end
            end
            SHOW: begin
                armed_d = armed_q | ~bell_s;
                if (armed_q && bell_s) begin
                    who_d   = bell_player(keypad_in);
                    rq_d    = right_in;
                    count_d = win_q;
                    state_d = JUDGE;
                end else if (tick_s) begin
                    div_d = DIV_LOAD;
                    if (win_q == 8'd0) begin
                        state_d = NEXT;
                    end else begin
                        win_d = win_q - 8'd1;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            JUDGE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!bell_s) begin
                    state_d = NEXT;
                end else begin
                    state_d = HOLD;
                end
            end
            NEXT: begin
                round_d = round_inc_s;
                if (round_inc_s == ROUND_LAST) begin
                    state_d = OVER;
                end else begin
                    state_d = DEAL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        card_req_d  = (state_d == DEAL);
        game_over_d = (state_d == OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            card_req_q  <= 1'b0;
            c1_q        <= 2'd0;
            n1_q        <= 3'd0;
            c2_q        <= 2'd0;
            n2_q        <= 3'd0;
            who_q       <= 2'b00;
            rq_q        <= 1'b0;
            count_q     <= 8'd0;
            round_q     <= 4'd0;
            game_over_q <= 1'b0;
            win_q       <= 8'd0;
            div_q       <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            card_req_q  <= card_req_d;
            c1_q        <= c1_d;
            n1_q        <= n1_d;
            c2_q        <= c2_d;
            n2_q        <= n2_d;
            who_q       <= who_d;
            rq_q        <= rq_d;
            count_q     <= count_d;
            round_q     <= round_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
            div_q       <= div_d;
            armed_q     <= armed_d;
        end
    end

    assign card_req  = card_req_q;
    assign c1        = c1_q;
    assign n1        = n1_q;
    assign c2        = c2_q;
    assign n2        = n2_q;
    assign who       = who_q;
    assign right_q   = rq_q;
    assign count     = count_q;
    assign round_cnt = round_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: two instances (TICK_DIV 1 and 4) share stimulus and are
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_round_sequencer;

    localparam int ROUNDS = 2;
    localparam int WINDOW = 10;

    localparam int PH_IDLE  = 0;
    localparam int PH_DEAL  = 1;
    localparam int PH_SHOW  = 2;
    localparam int PH_JUDGE = 3;
    localparam int PH_HOLD  = 4;
    localparam int PH_NEXT  = 5;
    localparam int PH_OVER  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] keypad_in = 4'd0;
    logic       card_valid = 1'b0;
    logic [9:0] card_data = 10'd0;
    logic       right_in = 1'b0;

    logic       card_req_o [2];
    logic [1:0] c1_o [2];
    logic [2:0] n1_o [2];
    logic [1:0] c2_o [2];
    logic [2:0] n2_o [2];
    logic [1:0] who_o [2];
    logic       rq_o [2];
    logic [7:0] count_o [2];
    logic [3:0] round_o [2];
    logic       go_o [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int         m_phase [2];
    int         m_elapsed [2];
    bit         m_armed [2];
    logic [9:0] m_cards [2];
    logic [1:0] m_who [2];
    bit         m_rq [2];
    int         m_cnt [2];
    int         m_rnd [2];

    always #5 clk = ~clk;

    round_sequencer #(.ROUNDS(ROUNDS), .WINDOW(WINDOW), .TICK_DIV(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .keypad_in(keypad_in),
        .card_req(card_req_o[0]), .card_valid(card_valid), .card_data(card_data),
        .c1(c1_o[0]), .n1(n1_o[0]), .c2(c2_o[0]), .n2(n2_o[0]),
        .right_in(right_in), .who(who_o[0]), .right_q(rq_o[0]), .count(count_o[0]),
        .round_cnt(round_o[0]), .game_over(go_o[0])
    );

    round_sequencer #(.ROUNDS(ROUNDS), .WINDOW(WINDOW), .TICK_DIV(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .keypad_in(keypad_in),
        .card_req(card_req_o[1]), .card_valid(card_valid), .card_data(card_data),
        .c1(c1_o[1]), .n1(n1_o[1]), .c2(c2_o[1]), .n2(n2_o[1]),
        .right_in(right_in), .who(who_o[1]), .right_q(rq_o[1]), .count(count_o[1]),
        .round_cnt(round_o[1]), .game_over(go_o[1])
    );

    function automatic int tdiv(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic bit bell(input logic [3:0] k);
        return (k == 4'b0111) || (k == 4'b1001);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: remaining window is derived from cycles spent showing, not from a divider.
    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            int rem;
            m_who[d] = 2'b00;
            if (rst) begin
                m_phase[d] = PH_IDLE; m_elapsed[d] = 0; m_armed[d] = 0;
                m_cards[d] = 10'd0; m_rq[d] = 0; m_cnt[d] = 0; m_rnd[d] = 0;
            end else begin
                case (m_phase[d])
                    PH_IDLE, PH_OVER: if (start) begin
                        m_rnd[d] = 0;
                        m_phase[d] = PH_DEAL;
                    end
                    PH_DEAL: if (card_valid) begin
                        m_cards[d] = card_data;
                        m_elapsed[d] = 0;
                        m_armed[d] = !bell(keypad_in);
                        m_phase[d] = PH_SHOW;
                    end
                    PH_SHOW: begin
                        rem = WINDOW - m_elapsed[d] / tdiv(d);
                        if (rem < 0) rem = 0;
                        if (m_armed[d] && bell(keypad_in)) begin
                            m_who[d] = (keypad_in == 4'b0111) ? 2'b01 : 2'b10;
                            m_rq[d] = right_in;
                            m_cnt[d] = rem;
                            m_phase[d] = PH_JUDGE;
                        end else if (rem == 0 && ((m_elapsed[d] + 1) % tdiv(d)) == 0) begin
                            m_phase[d] = PH_NEXT;
                        end else begin
                            m_elapsed[d]++;
                        end
                        if (!bell(keypad_in)) m_armed[d] = 1;
                    end
                    PH_JUDGE: m_phase[d] = PH_HOLD;
                    PH_HOLD:  if (!bell(keypad_in)) m_phase[d] = PH_NEXT;
                    PH_NEXT: begin
                        m_rnd[d]++;
                        m_phase[d] = (m_rnd[d] == ROUNDS) ? PH_OVER : PH_DEAL;
                    end
                    default: m_phase[d] = PH_IDLE;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [26:0] act, exp;
            act = {card_req_o[d], c1_o[d], n1_o[d], c2_o[d], n2_o[d], who_o[d], rq_o[d],
                   count_o[d], round_o[d], go_o[d]};
            exp = {(m_phase[d] == PH_DEAL), m_cards[d], m_who[d], m_rq[d],
                   8'(m_cnt[d]), 4'(m_rnd[d]), (m_phase[d] == PH_OVER)};
            check($sformatf("model_dut%0d", d), {5'd0, act}, {5'd0, exp});
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_outs_dut%0d", tag, d),
                  {card_req_o[d], c1_o[d], n1_o[d], c2_o[d], n2_o[d], who_o[d], rq_o[d],
                   count_o[d], round_o[d], go_o[d]}, 32'd0);
        end
    endtask

    initial begin
        steps(2);
        check_reset("reset");
        rst = 1'b0;

        // Game 1, round 1: press player 1 after 3 ticks.
        start = 1'b1; step(); start = 1'b0;
        check("deal_req0", card_req_o[0], 1'b1);
        card_valid = 1'b1; card_data = 10'b01_010_01_011; step(); card_valid = 1'b0;
        check("cards0", {c1_o[0], n1_o[0], c2_o[0], n2_o[0]}, 10'b01_010_01_011);
        check("show_req0", card_req_o[0], 1'b0);
        steps(3);
        keypad_in = 4'b0111; right_in = 1'b1; step();
        check("p1_who0", who_o[0], 2'b01);
        check("p1_rq0", rq_o[0], 1'b1);
        check("p1_count0", count_o[0], 8'd7);
        check("p1_count1", count_o[1], 8'd10);
        step();
        check("p1_strobe_end0", who_o[0], 2'b00);
        step();
        keypad_in = 4'b0000; steps(2);
        check("r1_round0", round_o[0], 4'd1);
        check("r1_req0", card_req_o[0], 1'b1);

        // Round 2: bell held through the deal is locked out until released.
        keypad_in = 4'b1001; right_in = 1'b0;
        card_valid = 1'b1; step(); card_valid = 1'b0;
        steps(5);
        check("lockout_who0", who_o[0], 2'b00);
        keypad_in = 4'b0000; steps(3);
        keypad_in = 4'b1001; step();
        check("p2_who0", who_o[0], 2'b10);
        check("p2_who1", who_o[1], 2'b10);
        check("p2_count0", count_o[0], 8'd2);
        check("p2_count1", count_o[1], 8'd8);
        keypad_in = 4'b0000; steps(3);
        check("over_go0", go_o[0], 1'b1);
        check("over_round0", round_o[0], 4'd2);
        step();
        check("over_hold0", go_o[0], 1'b1);

        // Game 2: silent expiry on the fast instance.
        start = 1'b1; step(); start = 1'b0;
        check("restart_go0", go_o[0], 1'b0);
        check("restart_round0", round_o[0], 4'd0);
        card_valid = 1'b1; step(); card_valid = 1'b0;
        steps(12);
        check("expire_round0", round_o[0], 4'd1);
        check("expire_req0", card_req_o[0], 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        check_reset("midgame_reset");

        // Press on the tick where the window reaches zero.
        start = 1'b1; step(); start = 1'b0;
        card_valid = 1'b1; step(); card_valid = 1'b0;
        steps(10);
        keypad_in = 4'b0111; right_in = 1'b1; step();
        check("zero_who0", who_o[0], 2'b01);
        check("zero_count0", count_o[0], 8'd0);
        check("zero_count1", count_o[1], 8'd8);
        keypad_in = 4'b0000; steps(3);

        // Reset during SHOW, then restart without reset.
        card_valid = 1'b1; step(); card_valid = 1'b0;
        steps(5);
        rst = 1'b1; step(); rst = 1'b0;
        check_reset("show_reset");
        start = 1'b1; step(); start = 1'b0;
        check("rs_req0", card_req_o[0], 1'b1);
        check("rs_round0", round_o[0], 4'd0);

        // Randomized play.
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: keypad_in = 4'b0111;
                    1: keypad_in = 4'b1001;
                    default: keypad_in = 4'($urandom_range(0, 15));
                endcase
            end
            card_valid = ($urandom_range(0, 2) == 0);
            card_data = 10'($urandom_range(0, 1023));
            right_in = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
